// File: rtl/fill_pkg.sv
// Shared types and constants for the rectangle filler.
package fill_pkg;

  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLOT = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SOLID   = 2'b00,
    CHECKER = 2'b01,
    STRIPES = 2'b10
  } mode_e;

  // Selects the secondary colour for the pixel; code 2'b11 falls back to solid.
  function automatic logic use_alt(input logic [1:0] mode, input logic x_lsb, input logic y_lsb);
    case (mode)
      CHECKER: return x_lsb ^ y_lsb;
      STRIPES: return y_lsb;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fill_rect_clip.sv
// Orders rectangle corners and clamps the far edges to the screen.
// Purely combinational; outputs are one bit wider than the inputs.
module fill_rect_clip #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic [X_W:0]   xa,
  output logic [X_W:0]   xb,
  output logic [Y_W:0]   ya,
  output logic [Y_W:0]   yb,
  output logic           empty
);

  localparam logic [X_W:0] X_MAX = (X_W+1)'(SCREEN_W - 1);
  localparam logic [Y_W:0] Y_MAX = (Y_W+1)'(SCREEN_H - 1);

  logic [X_W:0] x_hi;
  logic [Y_W:0] y_hi;

  always_comb begin
    xa   = (x0 <= x1) ? {1'b0, x0} : {1'b0, x1};
    x_hi = (x0 <= x1) ? {1'b0, x1} : {1'b0, x0};
    ya   = (y0 <= y1) ? {1'b0, y0} : {1'b0, y1};
    y_hi = (y0 <= y1) ? {1'b0, y1} : {1'b0, y0};
    xb   = (x_hi > X_MAX) ? X_MAX : x_hi;
    yb   = (y_hi > Y_MAX) ? Y_MAX : y_hi;
    // A rectangle starting beyond the visible area has nothing to draw.
    empty = (xa > X_MAX) || (ya > Y_MAX);
  end

endmodule

// File: rtl/fill_rect.sv
// Fills a clipped rectangle one pixel per clock in row-major order.
// First pixel one cycle after the job is taken; done holds until start drops.
module fill_rect
  import fill_pkg::*;
#(
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H,
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [X_W-1:0]      x1,
  input  logic [Y_W-1:0]      y0,
  input  logic [Y_W-1:0]      y1,
  input  logic [COLOUR_W-1:0] colour,
  input  logic [COLOUR_W-1:0] colour_alt,
  input  logic [1:0]          mode,
  output logic                done,
  output logic                busy,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot
);

  state_e state, state_nxt;

  logic [X_W:0] clip_xa, clip_xb;
  logic [Y_W:0] clip_ya, clip_yb;
  logic         clip_empty;

  logic [X_W:0]          xa_q, xb_q, x_q;
  logic [Y_W:0]          yb_q, y_q;
  logic [COLOUR_W-1:0]   colour_q, alt_q;
  logic [1:0]            mode_q;
  logic                  take_job, last_px, row_end;

  fill_rect_clip #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H),
    .X_W      (X_W),
    .Y_W      (Y_W)
  ) u_clip (
    .x0    (x0),
    .x1    (x1),
    .y0    (y0),
    .y1    (y1),
    .xa    (clip_xa),
    .xb    (clip_xb),
    .ya    (clip_ya),
    .yb    (clip_yb),
    .empty (clip_empty)
  );

  assign take_job = (state == IDLE) && start;
  assign row_end  = (x_q == xb_q);
  assign last_px  = row_end && (y_q == yb_q);
  assign busy     = (state == PLOT);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = clip_empty ? DONE : PLOT;
      PLOT:    if (last_px) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Job registers and scan counters are only meaningful once a job is taken.
  always_ff @(posedge clk) begin
    if (take_job) begin
      xa_q     <= clip_xa;
      xb_q     <= clip_xb;
      yb_q     <= clip_yb;
      x_q      <= clip_xa;
      y_q      <= clip_ya;
      colour_q <= colour;
      alt_q    <= colour_alt;
      mode_q   <= mode;
    end else if (state == PLOT) begin
      if (row_end) begin
        x_q <= xa_q;
        y_q <= y_q + 1'b1;
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done       <= 1'b0;
      vga_plot   <= 1'b0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
    end else begin
      done     <= (state == DONE) && start;
      vga_plot <= (state == PLOT);
      if (state == PLOT) begin
        vga_x      <= x_q[X_W-1:0];
        vga_y      <= y_q[Y_W-1:0];
        vga_colour <= use_alt(mode_q, x_q[0], y_q[0]) ? alt_q : colour_q;
      end
    end
  end

endmodule

// File: tb/tb_fill_rect.sv
// Randomised and directed self-checking bench for fill_rect.
module tb_fill_rect;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] colour, colour_alt;
  logic [1:0] mode;
  logic       done, busy, vga_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;

  int n_cmp = 0;
  int n_bad = 0;
  int act_x[$], act_y[$], act_c[$];
  int exp_x[$], exp_y[$], exp_c[$];

  fill_rect dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .x0         (x0),
    .x1         (x1),
    .y0         (y0),
    .y1         (y1),
    .colour     (colour),
    .colour_alt (colour_alt),
    .mode       (mode),
    .done       (done),
    .busy       (busy),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: expected pixel list straight from the ordering/clip/colour rules.
  function automatic void model(input int ax0, ax1, ay0, ay1, c, ca, m);
    int xa, xb, ya, yb;
    exp_x.delete(); exp_y.delete(); exp_c.delete();
    xa = (ax0 < ax1) ? ax0 : ax1;  xb = (ax0 < ax1) ? ax1 : ax0;
    ya = (ay0 < ay1) ? ay0 : ay1;  yb = (ay0 < ay1) ? ay1 : ay0;
    if (xb > 159) xb = 159;
    if (yb > 119) yb = 119;
    if (xa > 159 || ya > 119) return;
    for (int y = ya; y <= yb; y++)
      for (int x = xa; x <= xb; x++) begin
        exp_x.push_back(x);
        exp_y.push_back(y);
        if (m == 1)      exp_c.push_back(((x + y) % 2 == 1) ? ca : c);
        else if (m == 2) exp_c.push_back((y % 2 == 1) ? ca : c);
        else             exp_c.push_back(c);
      end
  endfunction

  // Launches one job and records every plotted pixel until done (or budget runs out).
  task automatic run_job(input int ax0, ax1, ay0, ay1, c, ca, m, input int budget,
                         output int done_cyc, output int last_cyc);
    act_x.delete(); act_y.delete(); act_c.delete();
    done_cyc = -1; last_cyc = -1;
    x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1);
    colour = 3'(c); colour_alt = 3'(ca); mode = 2'(m);
    start = 1'b1;
    @(posedge clk); #1;
    x0 = 8'($urandom); x1 = 8'($urandom); y0 = 7'($urandom); y1 = 7'($urandom);
    colour = 3'($urandom); colour_alt = 3'($urandom); mode = 2'($urandom);
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (vga_plot) begin
        act_x.push_back(int'(vga_x));
        act_y.push_back(int'(vga_y));
        act_c.push_back(int'(vga_colour));
        last_cyc = k;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
  endtask

  task automatic finish_job();
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if ({done, busy, vga_plot} !== 3'b000) begin n_bad++;
      $display("FAIL reset_flags: got %b want 000", {done, busy, vga_plot}); end
    n_cmp++; if (vga_x !== 8'd0 || vga_y !== 7'd0) begin n_bad++;
      $display("FAIL reset_xy: got (%0d,%0d) want (0,0)", vga_x, vga_y); end
    n_cmp++; if (vga_colour !== 3'd0) begin n_bad++;
      $display("FAIL reset_colour: got %0d want 0", vga_colour); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_screen();
    int dc, lc, badc;
    run_job(0, 159, 0, 119, 5, 2, 0, 20000, dc, lc);
    badc = 0;
    foreach (act_c[i]) if (act_c[i] != 5) badc++;
    n_cmp++; if (act_x.size() !== 19200) begin n_bad++;
      $display("FAIL full_count: got %0d want 19200", act_x.size()); end
    n_cmp++; if (badc !== 0) begin n_bad++;
      $display("FAIL full_colour: got %0d wrong pixels want 0", badc); end
    n_cmp++; if (dc !== 19201 || lc !== 19200) begin n_bad++;
      $display("FAIL full_timing: done at %0d last at %0d want 19201/19200", dc, lc); end
    if (act_x.size() == 19200) begin
      n_cmp++; if (act_x[19199] !== 159 || act_y[19199] !== 119) begin n_bad++;
        $display("FAIL full_last: got (%0d,%0d) want (159,119)", act_x[19199], act_y[19199]); end
    end
    finish_job();
  endtask

  task automatic test_corner_swap();
    int dc, lc;
    run_job(10, 7, 5, 3, 2, 4, 0, 100, dc, lc);
    n_cmp++; if (act_x.size() !== 12 || dc !== 13) begin n_bad++;
      $display("FAIL swap_count: got %0d plots done at %0d want 12/13", act_x.size(), dc); end
    if (act_x.size() == 12) begin
      n_cmp++; if (act_x[0] !== 7 || act_y[0] !== 3) begin n_bad++;
        $display("FAIL swap_first: got (%0d,%0d) want (7,3)", act_x[0], act_y[0]); end
      n_cmp++; if (act_x[3] !== 10 || act_y[3] !== 3 || act_x[4] !== 7 || act_y[4] !== 4) begin n_bad++;
        $display("FAIL swap_wrap: got (%0d,%0d)->(%0d,%0d) want (10,3)->(7,4)",
                 act_x[3], act_y[3], act_x[4], act_y[4]); end
      n_cmp++; if (act_x[11] !== 10 || act_y[11] !== 5) begin n_bad++;
        $display("FAIL swap_last: got (%0d,%0d) want (10,5)", act_x[11], act_y[11]); end
    end
    finish_job();
  endtask

  task automatic test_clip();
    int dc, lc;
    run_job(150, 200, 115, 127, 3, 0, 0, 200, dc, lc);
    n_cmp++; if (act_x.size() !== 50 || dc !== 51) begin n_bad++;
      $display("FAIL clip_count: got %0d plots done at %0d want 50/51", act_x.size(), dc); end
    if (act_x.size() == 50) begin
      n_cmp++; if (act_x[0] !== 150 || act_y[0] !== 115 || act_x[49] !== 159 || act_y[49] !== 119) begin
        n_bad++;
        $display("FAIL clip_ends: got (%0d,%0d)..(%0d,%0d) want (150,115)..(159,119)",
                 act_x[0], act_y[0], act_x[49], act_y[49]); end
    end
    finish_job();
    run_job(170, 180, 0, 10, 3, 0, 0, 50, dc, lc);
    n_cmp++; if (act_x.size() !== 0 || dc !== 1) begin n_bad++;
      $display("FAIL empty: got %0d plots done at %0d want 0/1", act_x.size(), dc); end
    finish_job();
  endtask

  task automatic test_checker();
    int dc, lc;
    int ec[4] = '{1, 6, 6, 1};
    run_job(0, 1, 0, 1, 1, 6, 1, 20, dc, lc);
    n_cmp++; if (act_c.size() !== 4) begin n_bad++;
      $display("FAIL checker_count: got %0d want 4", act_c.size()); end
    for (int i = 0; i < act_c.size() && i < 4; i++) begin
      n_cmp++; if (act_c[i] !== ec[i]) begin n_bad++;
        $display("FAIL checker_colour[%0d]: got %0d want %0d", i, act_c[i], ec[i]); end
    end
    finish_job();
  endtask

  task automatic test_random();
    int ax0, ax1, ay0, ay1, c, ca, m, dc, lc;
    for (int j = 0; j < 16; j++) begin
      ax0 = $urandom_range(0, 255);
      ax1 = ax0 + $urandom_range(0, 24) - 12;
      if (ax1 < 0) ax1 = 0;
      if (ax1 > 255) ax1 = 255;
      ay0 = $urandom_range(0, 127);
      ay1 = ay0 + $urandom_range(0, 16) - 8;
      if (ay1 < 0) ay1 = 0;
      if (ay1 > 127) ay1 = 127;
      c = $urandom_range(0, 7); ca = $urandom_range(0, 7); m = $urandom_range(0, 3);
      model(ax0, ax1, ay0, ay1, c, ca, m);
      run_job(ax0, ax1, ay0, ay1, c, ca, m, 1000, dc, lc);
      n_cmp++; if (act_x.size() !== exp_x.size() || dc !== exp_x.size() + 1) begin n_bad++;
        $display("FAIL rand%0d_count: got %0d plots done at %0d want %0d/%0d",
                 j, act_x.size(), dc, exp_x.size(), exp_x.size() + 1); end
      for (int i = 0; i < act_x.size() && i < exp_x.size(); i++) begin
        n_cmp++;
        if (act_x[i] !== exp_x[i] || act_y[i] !== exp_y[i] || act_c[i] !== exp_c[i]) begin
          n_bad++;
          $display("FAIL rand%0d_px%0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", j, i,
                   act_x[i], act_y[i], act_c[i], exp_x[i], exp_y[i], exp_c[i]); end
      end
      finish_job();
    end
  endtask

  task automatic test_reset_mid();
    int seen, extra;
    x0 = 8'd0; x1 = 8'd9; y0 = 7'd0; y1 = 7'd9; colour = 3'd7; colour_alt = 3'd0; mode = 2'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen < 5; k++) begin
      @(posedge clk); #1;
      if (vga_plot) seen++;
    end
    n_cmp++; if (seen !== 5 || busy !== 1'b1) begin n_bad++;
      $display("FAIL midrst_pre: got %0d plots busy=%b want 5 busy=1", seen, busy); end
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if ({vga_plot, done, busy} !== 3'b000) begin n_bad++;
      $display("FAIL midrst_flags: got %b want 000", {vga_plot, done, busy}); end
    rst = 1'b0;
    extra = 0;
    repeat (110) begin
      @(posedge clk); #1;
      if (vga_plot || done) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_bad++;
      $display("FAIL midrst_after: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_done_hold();
    int dc, lc, np, nd;
    run_job(2, 4, 2, 3, 1, 2, 0, 50, dc, lc);
    n_cmp++; if (act_x.size() !== 6 || dc !== 7) begin n_bad++;
      $display("FAIL hold_job: got %0d plots done at %0d want 6/7", act_x.size(), dc); end
    np = 0; nd = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (vga_plot) np++;
      if (!done || busy) nd++;
    end
    n_cmp++; if (np !== 0 || nd !== 0) begin n_bad++;
      $display("FAIL hold_retrigger: got %0d plots %0d not-done cycles want 0/0", np, nd); end
    finish_job();
    n_cmp++; if (done !== 1'b0) begin n_bad++;
      $display("FAIL hold_release: got done=%b want 0", done); end
    run_job(5, 5, 6, 8, 3, 4, 2, 20, dc, lc);
    n_cmp++; if (act_c.size() !== 3 || dc !== 4) begin n_bad++;
      $display("FAIL hold_newjob: got %0d plots done at %0d want 3/4", act_c.size(), dc); end
    if (act_c.size() == 3) begin
      n_cmp++; if (act_c[0] !== 3 || act_c[1] !== 4 || act_c[2] !== 3) begin n_bad++;
        $display("FAIL stripes: got %0d,%0d,%0d want 3,4,3", act_c[0], act_c[1], act_c[2]); end
    end
    finish_job();
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    x0 = '0; x1 = '0; y0 = '0; y1 = '0;
    colour = '0; colour_alt = '0; mode = '0;
    test_reset();
    test_full_screen();
    test_corner_swap();
    test_clip();
    test_checker();
    test_random();
    test_reset_mid();
    test_done_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
